t80_alu16_seq: RTL and testbench

Nibble-serial 16-bit arithmetic sequencer for the T80 core. It executes ADD/ADC/SUB/SBC on 16-bit register pairs (ADD HL,rr / ADC HL,rr / SBC HL,rr) by driving one shared 4-bit AddSub adder over four clock-enabled steps, chaining carry between nibbles. It produces the Z80 flag set (S, Z, H, V, N, C) at completion. It sits beside the 8-bit ALU and is started by the microcode sequencer.

---
 rtl/t80_alu16_pkg.sv | 43 ++++
 rtl/AddSub.sv | 24 ++
 rtl/t80_alu16_seq.sv | 158 +++++++++++++++
 tb/tb_t80_alu16_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t80_alu16_pkg.sv
// Shared definitions for the nibble-serial 16-bit arithmetic sequencer:
// operation encodings, FSM state enum, flag bit positions and op helpers.
package t80_alu16_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        N0,
        N1,
        N2,
        N3,
        DONE
    } state_t;

    // Bit positions inside flags = {S,Z,H,V,N,C}
    localparam int unsigned FLG_S = 5;
    localparam int unsigned FLG_Z = 4;
    localparam int unsigned FLG_H = 3;
    localparam int unsigned FLG_V = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 0;

    function automatic logic is_sub(input logic [1:0] o);
        return (o == OP_SUB) || (o == OP_SBC);
    endfunction

    // Carry fed into nibble 0; subtracts use A + ~B + 1 - borrow_in.
    function automatic logic cin_eff(input logic [1:0] o, input logic c);
        logic r;
        case (o)
            OP_ADD:  r = 1'b0;
            OP_ADC:  r = c;
            OP_SUB:  r = 1'b1;
            default: r = ~c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/AddSub.sv
// Generic adder/subtractor: Res = A + (Sub ? ~B : B) + Carry_In.
module AddSub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Carry_In,
    output logic [WIDTH-1:0] Res,
    output logic             Carry
);

    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum;

    // Conditional inversion of B followed by a carry-in add
    always_comb begin
        b_x = Sub ? ~B : B;
        sum = {1'b0, A} + {1'b0, b_x} + (WIDTH+1)'(Carry_In);
        Res   = sum[WIDTH-1:0];
        Carry = sum[WIDTH];
    end

endmodule

// File: rtl/t80_alu16_seq.sv
// Nibble-serial 16-bit ADD/ADC/SUB/SBC sequencer sharing one 4-bit AddSub.
// Optional feature macro: T80_ALU16_OVF_EN (defined: V flag computed,
// undefined: V forced to 0 and the overflow latches are not built).
module t80_alu16_seq
    import t80_alu16_pkg::*;
#(
    parameter int unsigned OP_W = 2
) (
    input  logic            CLK_n,
    input  logic            RESET_n,
    input  logic            CEN,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [15:0]     a,
    input  logic [15:0]     b,
    input  logic            cin,
    output logic            busy,
    output logic            done,
    output logic [15:0]     res,
    output logic [5:0]      flags
);

    state_t state, state_next;

    logic [15:0]     a_q, b_q;
    logic [OP_W-1:0] op_q;
    logic            carry_q;
    logic            half_q;
`ifdef T80_ALU16_OVF_EN
    logic            a15_q;
    logic            beff15_q;
`endif

    logic       accept;
    logic       sub_q;
    logic [3:0] a_nib, b_nib, sum_nib;
    logic       cout;
    logic [5:0] flags_next;

    assign accept = CEN && start && (state == IDLE || state == DONE);
    assign sub_q  = is_sub(op_q);

    // State register
    always_ff @(posedge CLK_n) begin
        if (!RESET_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; everything holds while CEN is low
    always_comb begin
        state_next = state;
        if (CEN) begin
            case (state)
                IDLE:    state_next = start ? N0 : IDLE;
                N0:      state_next = N1;
                N1:      state_next = N2;
                N2:      state_next = N3;
                N3:      state_next = DONE;
                DONE:    state_next = start ? N0 : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == N0) || (state == N1) || (state == N2) || (state == N3);
        done = (state == DONE);
    end

    // Nibble mux feeding the shared adder
    always_comb begin
        case (state)
            N1:      begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
            N2:      begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
            N3:      begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
            default: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
        endcase
    end

    AddSub #(
        .WIDTH(4)
    ) u_addsub (
        .A        (a_nib),
        .B        (b_nib),
        .Sub      (sub_q),
        .Carry_In (carry_q),
        .Res      (sum_nib),
        .Carry    (cout)
    );

    // Flags evaluated with the top nibble still coming out of the adder
    always_comb begin
        flags_next        = '0;
        flags_next[FLG_S] = sum_nib[3];
        flags_next[FLG_Z] = ({sum_nib, res[11:0]} == 16'h0000);
        flags_next[FLG_H] = half_q ^ sub_q;
        flags_next[FLG_N] = sub_q;
        flags_next[FLG_C] = cout ^ sub_q;
`ifdef T80_ALU16_OVF_EN
        flags_next[FLG_V] = (a15_q == beff15_q) && (sum_nib[3] != a15_q);
`else
        flags_next[FLG_V] = 1'b0;
`endif
    end

    // Operand latches, carry chain, result nibbles and flags
    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            half_q   <= 1'b0;
            res      <= '0;
            flags    <= '0;
`ifdef T80_ALU16_OVF_EN
            a15_q    <= 1'b0;
            beff15_q <= 1'b0;
`endif
        end else if (CEN) begin
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                op_q     <= op;
                carry_q  <= cin_eff(op, cin);
`ifdef T80_ALU16_OVF_EN
                a15_q    <= a[15];
                beff15_q <= b[15] ^ is_sub(op);
`endif
            end
            case (state)
                N0: begin
                    res[3:0] <= sum_nib;
                    carry_q  <= cout;
                end
                N1: begin
                    res[7:4] <= sum_nib;
                    carry_q  <= cout;
                end
                N2: begin
                    res[11:8] <= sum_nib;
                    carry_q   <= cout;
                    half_q    <= cout;
                end
                N3: begin
                    res[15:12] <= sum_nib;
                    carry_q    <= cout;
                    flags      <= flags_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t80_alu16_seq.sv
// Self-checking bench for t80_alu16_seq: directed vectors, randomized ops
// against an integer-arithmetic reference model, CEN stalls, back-to-back
// operation and mid-operation reset.
module tb_t80_alu16_seq;

    logic        CLK_n = 1'b0;
    logic        RESET_n = 1'b0;
    logic        CEN = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] res;
    logic [5:0]  flags;

    int checks = 0;
    int failures = 0;

    t80_alu16_seq #(.OP_W(2)) dut (
        .CLK_n   (CLK_n),
        .RESET_n (RESET_n),
        .CEN     (CEN),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .flags   (flags)
    );

    always #5 CLK_n = ~CLK_n;

`ifdef T80_ALU16_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    // Reference: plain signed/unsigned integer arithmetic on whole operands
    function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                  input logic c, output logic [15:0] r, output logic [5:0] f);
        int ux, uy, sx, sy, k, full, low, sres;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        k  = (o[0] && c) ? 1 : 0;
        if (o[1] == 1'b0) begin
            full = ux + uy + k;
            low  = (ux & 'hFFF) + (uy & 'hFFF) + k;
            sres = sx + sy + k;
            f[0] = full > 'hFFFF;
            f[3] = low > 'hFFF;
        end else begin
            full = ux - uy - k;
            low  = (ux & 'hFFF) - (uy & 'hFFF) - k;
            sres = sx - sy - k;
            f[0] = full < 0;
            f[3] = low < 0;
        end
        r    = 16'(full);
        f[5] = r[15];
        f[4] = (r == 16'h0000);
        f[2] = OVF && (sres > 32767 || sres < -32768);
        f[1] = o[1];
    endfunction

    // Issue one op from a negedge with CEN high; returns edges from the accept
    // edge to the edge after which done is seen (accept edge counts as 1).
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic c, output int lat, output bit to);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(posedge CLK_n);
        lat = 1;
        to = 1'b0;
        @(negedge CLK_n);
        start = 1'b0;
        op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        while (!done && !to) begin
            @(posedge CLK_n);
            lat++;
            @(negedge CLK_n);
            if (lat >= 50) to = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        repeat (2) @(posedge CLK_n);
        @(negedge CLK_n);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 16'h0000 || flags !== 6'h00) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b res=%h flags=%b, required 0 0 0000 000000",
                     busy, done, res, flags);
        end
        RESET_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops   [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [15:0] as    [5] = '{16'h0FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
        logic [15:0] bs    [5] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
        logic        cs    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] rexp  [5] = '{16'h1000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [5:0]  fexp  [5] = '{6'b001000, 6'b011001, 6'b101011, 6'b001110, 6'b101100};
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            logic [5:0] fe;
            fe = fexp[i];
            if (!OVF) fe[2] = 1'b0;
            do_op(ops[i], as[i], bs[i], cs[i], lat, to);
            checks++;
            if (to || lat !== 5) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d edges (timeout=%0d), required 5", i, lat, to);
            end
            checks++;
            if (res !== rexp[i]) begin
                failures++;
                $display("FAIL directed_res[%0d]: got %h, required %h", i, res, rexp[i]);
            end
            checks++;
            if (flags !== fe) begin
                failures++;
                $display("FAIL directed_flags[%0d]: got %b, required %b", i, flags, fe);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        logic [1:0]  o;
        logic [15:0] x, y, r;
        logic        c;
        logic [5:0]  f;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            x = 16'($urandom);
            y = (i % 4 == 0) ? x : 16'($urandom);
            c = 1'($urandom);
            model(o, x, y, c, r, f);
            do_op(o, x, y, c, lat, to);
            checks++;
            if (to || res !== r || flags !== f) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h cin=%b: got res=%h flags=%b timeout=%0d, required res=%h flags=%b",
                         i, o, x, y, c, res, flags, to, r, f);
            end
        end
    endtask

    task automatic test_cen_stall_and_ignore();
        int lat;
        logic [15:0] r2;
        logic [5:0]  f2;
        logic [1:0]  o2;
        logic [15:0] x2, y2;
        logic        c2;
        op = 2'b00; a = 16'h1234; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(posedge CLK_n); lat = 1;
        @(negedge CLK_n); start = 1'b0;
        @(posedge CLK_n); lat++;
        @(negedge CLK_n); CEN = 1'b0;
        repeat (3) begin @(posedge CLK_n); lat++; end
        @(negedge CLK_n);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: busy=%b done=%b, required 1 0", busy, done);
        end
        CEN = 1'b1;
        @(posedge CLK_n); lat++;
        @(negedge CLK_n);
        start = 1'b1; op = 2'b10; a = 16'hFFFF; b = 16'h0F0F;
        @(posedge CLK_n); lat++;
        @(negedge CLK_n); start = 1'b0;
        while (!done && lat < 50) begin
            @(posedge CLK_n); lat++;
            @(negedge CLK_n);
        end
        checks++;
        if (lat !== 8 || done !== 1'b1) begin
            failures++;
            $display("FAIL stall_latency: got %0d edges done=%b, required 8", lat, done);
        end
        checks++;
        if (res !== 16'h2345 || flags !== 6'b000000) begin
            failures++;
            $display("FAIL stall_result: got res=%h flags=%b, required 2345 000000", res, flags);
        end
        // Frozen in DONE: done and result must hold
        CEN = 1'b0;
        repeat (2) @(posedge CLK_n);
        @(negedge CLK_n);
        checks++;
        if (done !== 1'b1 || res !== 16'h2345) begin
            failures++;
            $display("FAIL done_freeze: done=%b res=%h, required 1 2345", done, res);
        end
        CEN = 1'b1;
        // Back-to-back start issued while in DONE
        o2 = 2'($urandom); x2 = 16'($urandom); y2 = 16'($urandom); c2 = 1'($urandom);
        model(o2, x2, y2, c2, r2, f2);
        start = 1'b1; op = o2; a = x2; b = y2; cin = c2;
        @(posedge CLK_n); lat = 1;
        @(negedge CLK_n); start = 1'b0; a = '0; b = '0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        while (!done && lat < 50) begin
            @(posedge CLK_n); lat++;
            @(negedge CLK_n);
        end
        checks++;
        if (lat !== 5 || res !== r2 || flags !== f2) begin
            failures++;
            $display("FAIL b2b_result: got lat=%0d res=%h flags=%b, required 5 %h %b", lat, res, flags, r2, f2);
        end
        // Ignored mid-op start must not have been queued; done lasts one cycle
        @(posedge CLK_n);
        @(negedge CLK_n);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit to;
        logic [15:0] r;
        logic [5:0]  f;
        op = 2'b01; a = 16'hABCD; b = 16'h5432; cin = 1'b1; start = 1'b1;
        @(posedge CLK_n);
        @(negedge CLK_n); start = 1'b0;
        repeat (2) @(posedge CLK_n);
        @(negedge CLK_n);
        RESET_n = 1'b0;
        @(posedge CLK_n);
        @(negedge CLK_n);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 16'h0000 || flags !== 6'h00) begin
            failures++;
            $display("FAIL reset_mid_op: busy=%b done=%b res=%h flags=%b, required 0 0 0000 000000",
                     busy, done, res, flags);
        end
        RESET_n = 1'b1;
        @(negedge CLK_n);
        model(2'b11, 16'h1000, 16'h0001, 1'b0, r, f);
        do_op(2'b11, 16'h1000, 16'h0001, 1'b0, lat, to);
        checks++;
        if (to || lat !== 5 || res !== r || flags !== f) begin
            failures++;
            $display("FAIL post_reset_op: got lat=%0d res=%h flags=%b, required 5 %h %b", lat, res, flags, r, f);
        end
    endtask

    initial begin
        test_reset();
        @(negedge CLK_n);
        test_directed();
        test_random();
        test_cen_stall_and_ignore();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
